// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED ownership arbiter.
// State encodings double as the owner code driven on the owner port.
package led_arb_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'b00,
        S_USER  = 2'b01,
        S_HOST  = 2'b10,
        S_ADMIN = 2'b11
    } state_e;

    localparam logic [1:0] OWNER_BOOT  = 2'b00;
    localparam logic [1:0] OWNER_USER  = 2'b01;
    localparam logic [1:0] OWNER_HOST  = 2'b10;
    localparam logic [1:0] OWNER_ADMIN = 2'b11;

    function automatic logic [31:0] hold_cycles(input int unsigned clk_freq_hz,
                                                input int unsigned ovr_hold_ms);
        return 32'(clk_freq_hz / 1000 * ovr_hold_ms);
    endfunction

endpackage

// File: rtl/led_owner_arbiter_ovr_hold_timer.sv
// Host override hold timer: 32-bit up counter with clear/enable that flags
// the last cycle of the hold window.
module ovr_hold_timer
    import led_arb_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned OVR_HOLD_MS = 2000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [31:0] HOLD_CYCLES = hold_cycles(CLK_FREQ_HZ, OVR_HOLD_MS);

    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign expired = (count_q == HOLD_CYCLES - 32'd1);

endmodule

// File: rtl/led_owner_arbiter.sv
// Arbitrates the 4-LED bank between boot status, host override sessions and
// user logic; every output is registered from the previous cycle's state.
module led_owner_arbiter
    import led_arb_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned OVR_HOLD_MS = 2000,
    parameter int unsigned SLOW_BIT    = 25,
    parameter int unsigned FAST_BIT    = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       booting,
    input  logic       admin_mode,
    input  logic [3:0] user_led,
    input  logic       host_req,
    input  logic [3:0] host_pattern,
    input  logic       host_blink,
    input  logic       host_release,
    output logic       host_ack,
    output logic       host_busy,
    output logic [1:0] owner,
    output logic [3:0] led
);

    localparam int unsigned CNT_W = ((SLOW_BIT > FAST_BIT) ? SLOW_BIT : FAST_BIT) + 1;

    logic [CNT_W-1:0] blink_cnt_q;
    state_e           state_q, state_d;
    state_e           ret_q, ret_d;
    logic [3:0]       pattern_q;
    logic             blink_q;
    logic             accept;
    logic             expired;
    logic             s;
    logic             f;
    logic [3:0]       led_d;

    assign s = blink_cnt_q[SLOW_BIT];
    assign f = blink_cnt_q[FAST_BIT];

    ovr_hold_timer #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .OVR_HOLD_MS (OVR_HOLD_MS)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept || (state_q != S_HOST)),
        .en      (state_q == S_HOST),
        .expired (expired)
    );

    // Gating on host_ack keeps the ack from firing on back-to-back cycles.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        accept  = 1'b0;
        case (state_q)
            S_BOOT: begin
                if (!booting) begin
                    state_d = admin_mode ? S_ADMIN : S_USER;
                end
            end
            S_USER, S_ADMIN: begin
                if (host_req && !host_ack) begin
                    accept  = 1'b1;
                    ret_d   = state_q;
                    state_d = S_HOST;
                end
            end
            S_HOST: begin
                if (host_req && !host_ack) begin
                    accept = 1'b1;
                end else if (host_release || expired) begin
                    state_d = ret_q;
                end
            end
            default: state_d = S_BOOT;
        endcase
        if (booting && (state_q != S_BOOT)) begin
            state_d = S_BOOT;
            ret_d   = ret_q;
            accept  = 1'b0;
        end
    end

    always_comb begin
        led_d = 4'b0000;
        case (state_q)
            S_BOOT:  led_d = {s, ~s, s, ~s};
            S_ADMIN: led_d = {f, ~f, f, ~f};
            S_USER:  led_d = user_led;
            S_HOST:  led_d = blink_q ? (pattern_q & {4{f}}) : pattern_q;
            default: led_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_BOOT;
            ret_q       <= S_USER;
            blink_cnt_q <= '0;
            pattern_q   <= 4'b0000;
            blink_q     <= 1'b0;
            led         <= 4'b0000;
            owner       <= OWNER_BOOT;
            host_ack    <= 1'b0;
            host_busy   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            blink_cnt_q <= blink_cnt_q + CNT_W'(1);
            if (accept) begin
                pattern_q <= host_pattern;
                blink_q   <= host_blink;
            end
            led       <= led_d;
            owner     <= state_q;
            host_ack  <= accept;
            host_busy <= (state_q == S_HOST);
        end
    end

endmodule

// File: tb/tb_led_owner_arbiter.sv
// Scoreboard bench for led_owner_arbiter: directed stimulus queues expected
// outputs per cycle and expected ack cycles; a negedge monitor checks them.
module tb_led_owner_arbiter;

    logic       clk;
    logic       rst;
    logic       booting;
    logic       admin_mode;
    logic [3:0] user_led;
    logic       host_req;
    logic [3:0] host_pattern;
    logic       host_blink;
    logic       host_release;
    logic       host_ack;
    logic       host_busy;
    logic [1:0] owner;
    logic [3:0] led;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] mask;
        logic [7:0] val;
    } exp_t;

    exp_t expq[$];
    int   ackq[$];

    led_owner_arbiter #(
        .CLK_FREQ_HZ (1000),
        .OVR_HOLD_MS (10),
        .SLOW_BIT    (3),
        .FAST_BIT    (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .booting      (booting),
        .admin_mode   (admin_mode),
        .user_led     (user_led),
        .host_req     (host_req),
        .host_pattern (host_pattern),
        .host_blink   (host_blink),
        .host_release (host_release),
        .host_ack     (host_ack),
        .host_busy    (host_busy),
        .owner        (owner),
        .led          (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed vector: {ack, busy, owner[1:0], led[3:0]}
    task automatic expect_at(input int c, input string nm, input logic [7:0] m,
                             input logic [7:0] v);
        exp_t e;
        e.cyc  = c;
        e.name = nm;
        e.mask = m;
        e.val  = v;
        expq.push_back(e);
    endtask

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] obs;
        exp_t       keep[$];
        obs  = {host_ack, host_busy, owner, led};
        keep = {};
        foreach (expq[i]) begin
            if (expq[i].cyc == cyc) begin
                checks++;
                if (((obs ^ expq[i].val) & expq[i].mask) !== 8'h00) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", expq[i].name, cyc,
                             obs, expq[i].val, expq[i].mask);
                end
            end else if (expq[i].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s not sampled at cyc=%0d", expq[i].name, expq[i].cyc);
            end else begin
                keep.push_back(expq[i]);
            end
        end
        expq = keep;

        while (ackq.size() > 0 && ackq[0] < cyc) begin
            checks++;
            failures++;
            $display("FAIL ack_missing got=0 want=1 at cyc=%0d", ackq[0]);
            void'(ackq.pop_front());
        end
        if (host_ack === 1'b1) begin
            checks++;
            if (ackq.size() > 0 && ackq[0] == cyc) begin
                void'(ackq.pop_front());
            end else begin
                failures++;
                $display("FAIL ack_unexpected cyc=%0d got=1 want=0", cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        booting      = 1'b1;
        admin_mode   = 1'b0;
        user_led     = 4'b0000;
        host_req     = 1'b0;
        host_pattern = 4'b0000;
        host_blink   = 1'b0;
        host_release = 1'b0;

        // 1: boot slow blink, then hand over to user
        go_to(3);
        rst = 1'b0;
        expect_at(3, "reset_state", 8'hff, 8'h00);
        expect_at(4, "boot_led_c4", 8'hff, 8'h05);
        expect_at(11, "boot_led_c11", 8'h0f, 8'h05);
        expect_at(12, "boot_led_c12", 8'h0f, 8'h0a);
        expect_at(19, "boot_led_c19", 8'h0f, 8'h0a);
        expect_at(20, "boot_led_c20", 8'h0f, 8'h05);
        expect_at(28, "boot_led_c28", 8'h0f, 8'h0a);
        expect_at(30, "boot_owner", 8'hf0, 8'h00);
        expect_at(36, "boot_led_c36", 8'h0f, 8'h05);
        go_to(43);
        booting  = 1'b0;
        user_led = 4'b1100;
        expect_at(44, "boot_last", 8'hff, 8'h0a);
        expect_at(45, "user_entry", 8'hff, 8'h1c);

        // 2: request pending during boot, served in admin
        go_to(50);
        booting      = 1'b1;
        host_req     = 1'b1;
        host_pattern = 4'b0110;
        expect_at(51, "user_before_boot", 8'hff, 8'h1c);
        expect_at(52, "boot_no_ack", 8'hff, 8'h05);
        expect_at(60, "boot_req_held", 8'hf0, 8'h00);
        go_to(70);
        booting    = 1'b0;
        admin_mode = 1'b1;
        ackq.push_back(72);
        expect_at(72, "admin_ack", 8'hff, 8'hb5);
        go_to(72);
        host_req = 1'b0;
        expect_at(73, "host_entry", 8'hff, 8'h66);
        expect_at(82, "host_last", 8'hff, 8'h66);
        expect_at(83, "admin_return", 8'hff, 8'h3a);

        // 3: full-length session from user
        go_to(85);
        booting = 1'b1;
        go_to(88);
        booting    = 1'b0;
        admin_mode = 1'b0;
        expect_at(90, "user_again", 8'hff, 8'h1c);
        go_to(92);
        host_req     = 1'b1;
        host_pattern = 4'b1010;
        host_blink   = 1'b0;
        ackq.push_back(93);
        expect_at(93, "user_ack", 8'hff, 8'h9c);
        go_to(93);
        host_req = 1'b0;
        expect_at(94, "host3_first", 8'hff, 8'h6a);
        expect_at(98, "host3_mid", 8'hff, 8'h6a);
        expect_at(103, "host3_last", 8'hff, 8'h6a);
        expect_at(104, "user_after_timeout", 8'hff, 8'h1c);

        // 4: early release, then release together with a re-arm request
        go_to(106);
        host_req     = 1'b1;
        host_pattern = 4'b0011;
        ackq.push_back(107);
        go_to(107);
        host_req = 1'b0;
        expect_at(108, "host4_first", 8'hff, 8'h63);
        go_to(109);
        host_release = 1'b1;
        go_to(110);
        host_release = 1'b0;
        expect_at(110, "host4_release_cyc", 8'hff, 8'h63);
        expect_at(111, "user_after_release", 8'hff, 8'h1c);
        go_to(113);
        host_req     = 1'b1;
        host_pattern = 4'b0001;
        ackq.push_back(114);
        go_to(114);
        host_req = 1'b0;
        go_to(116);
        host_req     = 1'b1;
        host_release = 1'b1;
        host_pattern = 4'b1001;
        ackq.push_back(117);
        expect_at(117, "rearm_ack", 8'hff, 8'he1);
        go_to(117);
        host_req     = 1'b0;
        host_release = 1'b0;
        expect_at(118, "rearm_pattern", 8'hff, 8'h69);
        expect_at(127, "rearm_last", 8'hff, 8'h69);
        expect_at(128, "rearm_exit", 8'hff, 8'h1c);

        // 5: blinking override from admin
        go_to(130);
        booting = 1'b1;
        go_to(133);
        booting    = 1'b0;
        admin_mode = 1'b1;
        go_to(136);
        host_req     = 1'b1;
        host_pattern = 4'b1111;
        host_blink   = 1'b1;
        ackq.push_back(137);
        expect_at(137, "admin_ack2", 8'hff, 8'hb5);
        go_to(137);
        host_req = 1'b0;
        expect_at(138, "blink_on_a", 8'hff, 8'h6f);
        expect_at(140, "blink_off", 8'hff, 8'h60);
        expect_at(142, "blink_on_b", 8'hff, 8'h6f);
        expect_at(147, "blink_last", 8'hff, 8'h6f);
        expect_at(148, "admin_fast_a", 8'hff, 8'h35);
        expect_at(150, "admin_fast_b", 8'hff, 8'h3a);

        // 6: reset mid-session, then booting mid-session
        go_to(152);
        host_req     = 1'b1;
        host_pattern = 4'b0111;
        host_blink   = 1'b0;
        ackq.push_back(153);
        go_to(153);
        host_req = 1'b0;
        expect_at(154, "host6_active", 8'hff, 8'h67);
        go_to(155);
        rst = 1'b1;
        go_to(156);
        rst = 1'b0;
        expect_at(156, "midsession_reset", 8'hff, 8'h00);
        expect_at(157, "post_reset_boot", 8'hff, 8'h05);
        expect_at(158, "post_reset_admin", 8'hff, 8'h35);
        go_to(160);
        host_req     = 1'b1;
        host_pattern = 4'b1110;
        ackq.push_back(161);
        expect_at(161, "admin_ack3", 8'hff, 8'hb5);
        go_to(161);
        host_req = 1'b0;
        expect_at(162, "host6b_active", 8'hff, 8'h6e);
        go_to(163);
        booting      = 1'b1;
        host_req     = 1'b1;
        host_pattern = 4'b0001;
        expect_at(164, "host6b_last", 8'hff, 8'h6e);
        expect_at(165, "booting_drop", 8'hff, 8'h0a);
        go_to(166);
        host_req = 1'b0;
        expect_at(166, "booting_hold", 8'hff, 8'h0a);

        go_to(170);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL exp_queue_drain got=%0d want=0", expq.size());
        end
        checks++;
        if (ackq.size() != 0) begin
            failures++;
            $display("FAIL ack_queue_drain got=%0d want=0", ackq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_owner_arbiter.md
Name: led_owner_arbiter

Overview:
- Shares the board's 4-LED bank between three requesters: boot-status display, remote host override, and user logic.
- Sits downstream of the boot/admin mode controller and consumes its `booting` and `admin_mode` status.
- Grants LED ownership by system state.
- Admits timed host override sessions through a req/ack handshake and drives the registered `led` output.

Parameters:
- CLK_FREQ_HZ, 50_000_000, clock frequency used to derive the hold time.
- OVR_HOLD_MS, 2000, host override hold time in ms; HOLD_CYCLES = CLK_FREQ_HZ/1000*OVR_HOLD_MS, held in a 32-bit counter.
- SLOW_BIT, 25, blink counter bit for the slow blink.
- FAST_BIT, 23, blink counter bit for the fast blink.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- booting  in  1  boot window active, from the mode controller.
- admin_mode  in  1  admin mode selected, from the mode controller.
- user_led  in  4  LED value requested by user logic.
- host_req  in  1  level request for an override session; held until host_ack.
- host_pattern  in  4  override LED pattern, sampled on acceptance.
- host_blink  in  1  1 = gate the pattern with the fast blink; sampled on acceptance.
- host_release  in  1  single-cycle pulse that ends the active session early.
- host_ack  out  1  single-cycle acceptance pulse.
- host_busy  out  1  override session active.
- owner  out  2  current owner: 00 BOOT, 01 USER, 10 HOST, 11 ADMIN.
- led  out  4  registered LED drive.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=S_BOOT; ret=S_USER; led=0000; host_ack=0; host_busy=0; owner=00.
  - Blink counter and hold counter cleared.
  - Reset mid-session aborts the session with no ack.
- Blink counter: free-running, FAST/SLOW_BIT+1 bits wide, wraps silently. Define s = cnt[SLOW_BIT], f = cnt[FAST_BIT].
- All outputs are registered. `led` and `owner` reflect the state and inputs of the previous cycle (1-cycle latency).
- S_BOOT:
  - led = {s,~s,s,~s}.
  - host_req is left pending and not acknowledged.
  - booting=0 and admin_mode=1 -> S_ADMIN; booting=0 and admin_mode=0 -> S_USER.
- S_ADMIN:
  - led = {f,~f,f,~f}.
  - host_req=1 -> host_ack=1 next cycle; latch pattern and blink; ret=S_ADMIN; -> S_HOST.
- S_USER:
  - led = user_led.
  - host_req=1 -> accepted as in S_ADMIN, with ret=S_USER.
- S_HOST:
  - host_busy=1.
  - led = pattern when the latched blink=0; led = pattern & {4{f}} when blink=1.
  - The hold counter increments each cycle. Reaching HOLD_CYCLES-1 -> ret state; the timeout exits on that cycle.
  - host_release=1 -> ret state on the next edge.
  - host_req=1 re-arms the session: ack, relatch pattern and blink, hold counter = 0, stay in S_HOST.
  - host_req and host_release in the same cycle: req wins (re-arm).
  - host_req on the timeout cycle: req wins (re-arm).
- booting=1 observed in any state other than S_BOOT -> S_BOOT. Any session is dropped, host_busy=0, and no ack is issued.
- host_ack is never high two consecutive cycles. A requester still holding host_req after ack starts a new session (re-arm). Requesters must deassert on ack.
- Unused or illegal state encodings -> S_BOOT.

Decomposition:
- Package led_arb_pkg holds:
  - the state enum (S_BOOT, S_USER, S_HOST, S_ADMIN), whose values equal the `owner` encoding;
  - the owner code constants;
  - the HOLD_CYCLES computation as a function of CLK_FREQ_HZ and OVR_HOLD_MS.
- One sub-module, ovr_hold_timer:
  - 32-bit counter with clear/enable;
  - `expired` output = (count == HOLD_CYCLES-1);
  - synchronous active-high rst.

Test Plan:
All tests use CLK_FREQ_HZ=1000, OVR_HOLD_MS=10 (HOLD_CYCLES=10), SLOW_BIT=3, FAST_BIT=1.
1. Release rst with booting=1 for 40 cycles -> led toggles between 0101 and 1010 every 8 cycles; owner=00. Drop booting with admin_mode=0 -> owner=01 and led=user_led (user_led=1100 -> led=1100) one cycle after the state change.
2. booting=1, host_req=1 for 20 cycles -> no host_ack. Drop booting with admin_mode=1 -> S_ADMIN, then host_ack pulses once; owner=10; led=pattern.
3. In S_USER: host_req with pattern=1010, blink=0 -> ack 1 cycle; led=1010 for exactly 10 cycles; then owner=01 and led=user_led; host_busy falls with the exit.
4. In S_HOST: host_release on cycle 3 -> exit to ret state, led=user_led next cycle. Repeat with host_req+host_release together -> re-arm, stays HOST for 10 more cycles with the new pattern.
5. blink=1, pattern=1111 in S_ADMIN -> led alternates 1111/0000 every 2 cycles; on timeout returns to S_ADMIN fast pattern.
6. Assert rst mid-session and then booting=1 mid-session -> both yield owner=00, host_busy=0; led=0000 after rst, and the boot slow pattern after booting re-asserts.
